// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
//
// Purpose: shared types and constants for the multicycle accumulator CPU
//          control unit. It holds the controller state encoding (which is
//          also shown on the seven-segment debug display), the instruction
//          opcode constants, and the ALU operation codes driven on
//          aluControl.
//
// Contents:
//   state_t    - 4-bit controller state encoding (exported on stateDbg)
//   opcode_t   - 4-bit opcode type plus OP_* constants (ir1[7:4])
//   alu_op_t   - 3-bit ALU control type plus ALU_* constants
//   HOLD_W     - width of the post-reset fetch hold counter
//   opcode_is_illegal() - true for the reserved opcodes A..E
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

  // The numeric values are visible outside the controller on stateDbg, so
  // they are pinned explicitly rather than left to the enum default.
  typedef enum logic [3:0] {
    FETCH1 = 4'd0,
    FETCH2 = 4'd1,
    DECODE = 4'd2,
    EXEC   = 4'd3,
    WB     = 4'd4,
    WB_IMM = 4'd5,
    MEM_RD = 4'd6,
    MEM_WB = 4'd7,
    MEM_WR = 4'd8,
    JUMP   = 4'd9,
    HALT   = 4'd10
  } state_t;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_NOP = 4'h0;
  localparam opcode_t OP_ADD = 4'h1;
  localparam opcode_t OP_SUB = 4'h2;
  localparam opcode_t OP_AND = 4'h3;
  localparam opcode_t OP_OR  = 4'h4;
  localparam opcode_t OP_LDI = 4'h5;
  localparam opcode_t OP_LD  = 4'h6;
  localparam opcode_t OP_ST  = 4'h7;
  localparam opcode_t OP_JMP = 4'h8;
  localparam opcode_t OP_JZ  = 4'h9;
  localparam opcode_t OP_HLT = 4'hF;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_ADD    = 3'b000;
  localparam alu_op_t ALU_SUB    = 3'b001;
  localparam alu_op_t ALU_AND    = 3'b010;
  localparam alu_op_t ALU_OR     = 3'b011;
  localparam alu_op_t ALU_PASS_B = 3'b100;

  // The hold counter only needs to cover 0..7 extra cycles.
  localparam int unsigned HOLD_W = 3;

  // Opcodes A..E are reserved; everything else has a defined meaning.
  function automatic logic opcode_is_illegal(input opcode_t op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/instr_class_decoder.sv
// ---------------------------------------------------------------------------
// instr_class_decoder
//
// Purpose: purely combinational classification of the 4-bit opcode held in
//          ir1[7:4]. The controller FSM uses the class flags to pick the
//          execution path after DECODE and uses alu_op to drive aluControl
//          during EXEC/WB of the arithmetic/logic instructions.
//
// Ports:
//   opcode     in   4  instruction opcode (ir1[7:4])
//   is_alu     out  1  ADD/SUB/AND/OR (accumulator op ir2)
//   is_ldi     out  1  load immediate
//   is_ld      out  1  load from memory
//   is_st      out  1  store to memory
//   is_jmp     out  1  unconditional jump
//   is_jz      out  1  jump if zero flag set
//   is_hlt     out  1  halt
//   is_illegal out  1  reserved opcode A..E
//   alu_op     out  3  ALU operation for the ALU class, ADD otherwise
// ---------------------------------------------------------------------------
module instr_class_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_alu,
  output logic       is_ldi,
  output logic       is_ld,
  output logic       is_st,
  output logic       is_jmp,
  output logic       is_jz,
  output logic       is_hlt,
  output logic       is_illegal,
  output logic [2:0] alu_op
);

  // NOP falls through with every flag low; the controller treats "no class
  // flag set" as go straight back to FETCH1.
  always_comb begin
    is_alu     = 1'b0;
    is_ldi     = 1'b0;
    is_ld      = 1'b0;
    is_st      = 1'b0;
    is_jmp     = 1'b0;
    is_jz      = 1'b0;
    is_hlt     = 1'b0;
    is_illegal = opcode_is_illegal(opcode);
    alu_op     = ALU_ADD;

    case (opcode)
      OP_ADD: begin
        is_alu = 1'b1;
        alu_op = ALU_ADD;
      end
      OP_SUB: begin
        is_alu = 1'b1;
        alu_op = ALU_SUB;
      end
      OP_AND: begin
        is_alu = 1'b1;
        alu_op = ALU_AND;
      end
      OP_OR: begin
        is_alu = 1'b1;
        alu_op = ALU_OR;
      end
      OP_LDI: is_ldi = 1'b1;
      OP_LD:  is_ld  = 1'b1;
      OP_ST:  is_st  = 1'b1;
      OP_JMP: is_jmp = 1'b1;
      OP_JZ:  is_jz  = 1'b1;
      OP_HLT: is_hlt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Purpose: control FSM for the 8-bit multicycle accumulator CPU. It fetches
//          the two instruction bytes, decodes the opcode and sequences the
//          execute / memory / writeback steps by driving every datapath
//          select and write enable. The FSM advances one state per cycle in
//          which `step` is high, so the IO top can single-step or free-run.
//
// Configuration:
//   ILLEGAL_TRAP_EN (macro) - when defined, a reserved opcode (A..E) sends
//                             the controller to HALT and raises `illegal`
//                             until reset. When undefined, reserved opcodes
//                             behave as NOP and `illegal` is tied low.
//
// Parameters:
//   RESET_PC_HOLD - extra steps spent in FETCH1 after reset before the first
//                   fetch (0..7).
//
// Ports:
//   clk        in   1  system clock
//   reset      in   1  synchronous, active-high reset
//   step       in   1  advance enable for state, zero flag and hold counter
//   opcode     in   4  ir1[7:4]
//   zero       in   1  ALU result == 0 (combinational)
//   pcSelect   out  1  PC source: 0 = ALU (PC+1), 1 = ir2 jump target
//   pcEnable   out  1  PC write
//   adrSelect  out  1  memory address: 0 = PC, 1 = ir2
//   ir1En      out  1  load ir1
//   ir2En      out  1  load ir2
//   op1Sel     out  1  ALU A: 0 = PC, 1 = accumulator
//   op2Sel     out  1  ALU B: 0 = constant 1, 1 = ir2 / memory read data
//   regWrite   out  1  accumulator write
//   memEnable  out  1  memory write strobe
//   aluControl out  3  ALU operation (see cpu_ctrl_pkg)
//   halted     out  1  controller is in HALT
//   illegal    out  1  illegal-opcode trap flag
//   stateDbg   out  4  current state encoding
// ---------------------------------------------------------------------------
module multicycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned RESET_PC_HOLD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic [3:0] opcode,
  input  logic       zero,
  output logic       pcSelect,
  output logic       pcEnable,
  output logic       adrSelect,
  output logic       ir1En,
  output logic       ir2En,
  output logic       op1Sel,
  output logic       op2Sel,
  output logic       regWrite,
  output logic       memEnable,
  output logic [2:0] aluControl,
  output logic       halted,
  output logic       illegal,
  output logic [3:0] stateDbg
);

  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_PC_HOLD);

  state_t            state;
  state_t            state_next;
  logic              zflag;
  logic              zflag_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_next;
  logic              wr_ok;

  logic              is_alu;
  logic              is_ldi;
  logic              is_ld;
  logic              is_st;
  logic              is_jmp;
  logic              is_jz;
  logic              is_hlt;
  logic              is_illegal;
  logic [2:0]        alu_op;

`ifdef ILLEGAL_TRAP_EN
  logic              illegal_q;
  logic              illegal_next;
`endif

  instr_class_decoder u_decoder (
    .opcode     (opcode),
    .is_alu     (is_alu),
    .is_ldi     (is_ldi),
    .is_ld      (is_ld),
    .is_st      (is_st),
    .is_jmp     (is_jmp),
    .is_jz      (is_jz),
    .is_hlt     (is_hlt),
    .is_illegal (is_illegal),
    .alu_op     (alu_op)
  );

  // Every write enable is qualified with this, so a paused (step=0) or
  // resetting controller can never disturb the datapath, whatever state the
  // register currently holds.
  assign wr_ok = step & ~reset;

  // Next-state, zero-flag and hold-counter logic. Nothing moves unless step
  // is high. The zero flag is captured only in the states where the ALU is
  // computing the value that is written back to the accumulator.
  always_comb begin
    state_next = state;
    zflag_next = zflag;
    hold_next  = hold_cnt;
`ifdef ILLEGAL_TRAP_EN
    illegal_next = illegal_q;
`endif

    if (step) begin
      case (state)
        FETCH1: begin
          // The post-reset hold burns steps here without fetching; once the
          // counter reaches zero it stays there until the next reset.
          if (hold_cnt != '0) begin
            hold_next = hold_cnt - 1'b1;
          end else begin
            state_next = FETCH2;
          end
        end
        FETCH2: state_next = DECODE;
        DECODE: begin
          if (is_alu) begin
            state_next = EXEC;
          end else if (is_ldi) begin
            state_next = WB_IMM;
          end else if (is_ld) begin
            state_next = MEM_RD;
          end else if (is_st) begin
            state_next = MEM_WR;
          end else if (is_jmp || is_jz) begin
            state_next = JUMP;
          end else if (is_hlt) begin
            state_next = HALT;
          end else if (is_illegal) begin
`ifdef ILLEGAL_TRAP_EN
            state_next   = HALT;
            illegal_next = 1'b1;
`else
            state_next = FETCH1;
`endif
          end else begin
            state_next = FETCH1;
          end
        end
        EXEC: begin
          zflag_next = zero;
          state_next = WB;
        end
        WB: state_next = FETCH1;
        WB_IMM: begin
          // With PASS_B selected the ALU result is ir2 itself, so `zero`
          // reports ir2 == 0.
          zflag_next = zero;
          state_next = FETCH1;
        end
        MEM_RD: state_next = MEM_WB;
        MEM_WB: begin
          zflag_next = zero;
          state_next = FETCH1;
        end
        MEM_WR: state_next = FETCH1;
        JUMP:   state_next = FETCH1;
        HALT:   state_next = HALT;
        default: state_next = FETCH1;
      endcase
    end
  end

  // State registers. Reset abandons any partly executed instruction and
  // reloads the fetch hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH1;
      zflag    <= 1'b0;
      hold_cnt <= HOLD_INIT;
    end else begin
      state    <= state_next;
      zflag    <= zflag_next;
      hold_cnt <= hold_next;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  // Sticky trap flag: only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_next;
    end
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // Moore output decode. Selects follow the registered state alone; write
  // enables are additionally gated by wr_ok. The PC increment during fetch
  // reuses the ALU as PC + 1 (A = PC, B = constant 1, ADD).
  always_comb begin
    pcSelect   = 1'b0;
    pcEnable   = 1'b0;
    adrSelect  = 1'b0;
    ir1En      = 1'b0;
    ir2En      = 1'b0;
    op1Sel     = 1'b0;
    op2Sel     = 1'b0;
    regWrite   = 1'b0;
    memEnable  = 1'b0;
    aluControl = ALU_ADD;
    halted     = 1'b0;

    case (state)
      FETCH1: begin
        if (hold_cnt == '0) begin
          ir1En    = wr_ok;
          pcEnable = wr_ok;
        end
      end
      FETCH2: begin
        ir2En    = wr_ok;
        pcEnable = wr_ok;
      end
      DECODE: ;
      EXEC: begin
        op1Sel     = 1'b1;
        op2Sel     = 1'b1;
        aluControl = alu_op;
      end
      WB: begin
        op1Sel     = 1'b1;
        op2Sel     = 1'b1;
        aluControl = alu_op;
        regWrite   = wr_ok;
      end
      WB_IMM: begin
        op2Sel     = 1'b1;
        aluControl = ALU_PASS_B;
        regWrite   = wr_ok;
      end
      MEM_RD: begin
        adrSelect = 1'b1;
      end
      MEM_WB: begin
        adrSelect  = 1'b1;
        op2Sel     = 1'b1;
        aluControl = ALU_PASS_B;
        regWrite   = wr_ok;
      end
      MEM_WR: begin
        adrSelect = 1'b1;
        op1Sel    = 1'b1;
        memEnable = wr_ok;
      end
      JUMP: begin
        // A not-taken JZ leaves the PC alone: it already points past the
        // two-byte instruction after FETCH2.
        pcSelect = 1'b1;
        pcEnable = wr_ok & (is_jmp | (is_jz & zflag));
      end
      HALT: begin
        halted = 1'b1;
      end
      default: ;
    endcase
  end

  assign stateDbg = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//
// Self-checking bench for multicycle_controller. A behavioural model keeps a
// queue of the phases still to run for the current instruction (a small
// microprogram built from the instruction class); a negedge process compares
// every DUT output against that model each cycle. Directed sequences pin the
// model with hand-computed step counts and output values, then a randomized
// run with random step, zero, opcode and reset exercises the rest.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

  localparam int HOLD = 3;

  localparam int S_F1  = 0;
  localparam int S_F2  = 1;
  localparam int S_DEC = 2;
  localparam int S_EX  = 3;
  localparam int S_WB  = 4;
  localparam int S_WBI = 5;
  localparam int S_MRD = 6;
  localparam int S_MWB = 7;
  localparam int S_MWR = 8;
  localparam int S_JMP = 9;
  localparam int S_HLT = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       step;
  logic [3:0] opcode;
  logic       zero;
  logic       pcSelect, pcEnable, adrSelect, ir1En, ir2En;
  logic       op1Sel, op2Sel, regWrite, memEnable, halted, illegal;
  logic [2:0] aluControl;
  logic [3:0] stateDbg;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  // Behavioural model state.
  int plan[$];
  int mHold;
  bit mZ;
  bit mIll;

  // Monitor counters.
  int  regWCount = 0;
  int  memCount = 0;
  int  enNoStep = 0;
  logic jPcEn = 1'b0;
  logic jPcSel = 1'b0;

  multicycle_controller #(.RESET_PC_HOLD(HOLD)) dut (
    .clk        (clk),
    .reset      (reset),
    .step       (step),
    .opcode     (opcode),
    .zero       (zero),
    .pcSelect   (pcSelect),
    .pcEnable   (pcEnable),
    .adrSelect  (adrSelect),
    .ir1En      (ir1En),
    .ir2En      (ir2En),
    .op1Sel     (op1Sel),
    .op2Sel     (op2Sel),
    .regWrite   (regWrite),
    .memEnable  (memEnable),
    .aluControl (aluControl),
    .halted     (halted),
    .illegal    (illegal),
    .stateDbg   (stateDbg)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mState();
    return (plan.size() > 0) ? plan[0] : -1;
  endfunction

  // Model update: consume one phase per step; after DECODE append the body
  // that the instruction class calls for.
  always @(posedge clk) begin : model
    int st;
    if (reset) begin
      plan.delete();
      plan.push_back(S_F1);
      plan.push_back(S_F2);
      plan.push_back(S_DEC);
      mHold = HOLD;
      mZ    = 1'b0;
      mIll  = 1'b0;
    end else if (step && plan.size() > 0) begin
      st = plan[0];
      if (st == S_F1 && mHold > 0) begin
        mHold--;
      end else if (st != S_HLT) begin
        if (st == S_EX || st == S_WBI || st == S_MWB) mZ = zero;
        void'(plan.pop_front());
        if (st == S_DEC) begin
          case (opcode)
            4'h0: ;
            4'h1, 4'h2, 4'h3, 4'h4: begin
              plan.push_back(S_EX);
              plan.push_back(S_WB);
            end
            4'h5: plan.push_back(S_WBI);
            4'h6: begin
              plan.push_back(S_MRD);
              plan.push_back(S_MWB);
            end
            4'h7: plan.push_back(S_MWR);
            4'h8, 4'h9: plan.push_back(S_JMP);
            4'hF: plan.push_back(S_HLT);
            default: begin
`ifdef ILLEGAL_TRAP_EN
              plan.push_back(S_HLT);
              mIll = 1'b1;
`endif
            end
          endcase
        end
        if (plan.size() == 0) begin
          plan.push_back(S_F1);
          plan.push_back(S_F2);
          plan.push_back(S_DEC);
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : compare
    int   st;
    logic en;
    logic ePcSel, ePcEn, eAdr, eIr1, eIr2, eOp1, eOp2, eRegW, eMem, eHalt;
    logic [2:0] eAlu;
    if (checkEn) begin
      st = mState();
      en = step && !reset;
      {ePcSel, ePcEn, eAdr, eIr1, eIr2, eOp1, eOp2, eRegW, eMem, eHalt} = '0;
      eAlu = 3'b000;
      case (st)
        S_F1: if (mHold == 0) begin eIr1 = en; ePcEn = en; end
        S_F2: begin eIr2 = en; ePcEn = en; end
        S_EX: begin eOp1 = 1; eOp2 = 1; eAlu = 3'(opcode - 4'd1); end
        S_WB: begin eOp1 = 1; eOp2 = 1; eAlu = 3'(opcode - 4'd1); eRegW = en; end
        S_WBI: begin eOp2 = 1; eAlu = 3'b100; eRegW = en; end
        S_MRD: eAdr = 1;
        S_MWB: begin eAdr = 1; eOp2 = 1; eAlu = 3'b100; eRegW = en; end
        S_MWR: begin eAdr = 1; eOp1 = 1; eMem = en; end
        S_JMP: begin ePcSel = 1; ePcEn = en && (opcode == 4'h8 || mZ); end
        S_HLT: eHalt = 1;
        default: ;
      endcase
      checkOutput("stateDbg",   8'(stateDbg),   8'(st));
      checkOutput("pcSelect",   8'(pcSelect),   8'(ePcSel));
      checkOutput("pcEnable",   8'(pcEnable),   8'(ePcEn));
      checkOutput("adrSelect",  8'(adrSelect),  8'(eAdr));
      checkOutput("ir1En",      8'(ir1En),      8'(eIr1));
      checkOutput("ir2En",      8'(ir2En),      8'(eIr2));
      checkOutput("op1Sel",     8'(op1Sel),     8'(eOp1));
      checkOutput("op2Sel",     8'(op2Sel),     8'(eOp2));
      checkOutput("regWrite",   8'(regWrite),   8'(eRegW));
      checkOutput("memEnable",  8'(memEnable),  8'(eMem));
      checkOutput("aluControl", 8'(aluControl), 8'(eAlu));
      checkOutput("halted",     8'(halted),     8'(eHalt));
      checkOutput("illegal",    8'(illegal),    8'(mIll));
    end
  end

  // Event monitor used by the directed literal checks.
  always @(negedge clk) begin : monitor
    if (regWrite) regWCount++;
    if (memEnable) memCount++;
    if (!step && (pcEnable || ir1En || ir2En || regWrite || memEnable)) enNoStep++;
    if (stateDbg == 4'd9 && step && !reset) begin
      jPcEn  = pcEnable;
      jPcSel = pcSelect;
    end
  end

  task automatic doReset();
    reset = 1'b1;
    step  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Runs one instruction from FETCH1 until the model is back in FETCH1 (or
  // in HALT). zmode: 0/1 constant zero, 2 random. smode: 0 free-run,
  // 1 alternating step, 2 random step. Returns the number of step=1 cycles.
  task automatic applyStimulus(input logic [3:0] op, input int zmode, input int smode,
                               output int steps);
    int n;
    bit left;
    n = 0;
    left = 1'b0;
    steps = 0;
    opcode = op;
    while (n < 200) begin
      case (smode)
        0: step = 1'b1;
        1: step = (n % 2 == 0);
        default: step = 1'($urandom_range(0, 1));
      endcase
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      if (step) steps++;
      @(posedge clk);
      #1;
      n++;
      if (mState() != S_F1) left = 1'b1;
      if ((left && mState() == S_F1) || mState() == S_HLT) break;
    end
    if (n >= 200) checkOutput("instrTimeout", 8'(n), 8'd0);
  endtask

  initial begin : watchdog
    #5ms;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stimulus
    int steps;
    int rw0, mem0, ens0;
    reset = 1'b1;
    step = 1'b0;
    opcode = 4'h0;
    zero = 1'b0;

    // Test A: reset values, post-reset fetch hold, then LDI/ADD/ST/HLT.
    $display("[TB] program LDI ADD ST HLT");
    doReset();
    checkEn = 1'b1;
    rw0 = regWCount;
    mem0 = memCount;
    @(negedge clk);
    checkOutput("rstState",   8'(stateDbg), 8'd0);
    checkOutput("rstHalted",  8'(halted),   8'd0);
    checkOutput("rstIllegal", 8'(illegal),  8'd0);
    @(posedge clk);
    #1;
    for (int k = 1; k <= 4; k++) begin
      step = 1'b1;
      @(negedge clk);
      checkOutput("holdIr1En", 8'(ir1En), (k == 4) ? 8'd1 : 8'd0);
      if (k < 4) begin
        @(posedge clk);
        #1;
      end
    end
    applyStimulus(4'h5, 0, 0, steps);
    checkOutput("stepsLDI", 8'(steps), 8'd4);
    applyStimulus(4'h1, 0, 0, steps);
    checkOutput("stepsADD", 8'(steps), 8'd5);
    applyStimulus(4'h7, 0, 0, steps);
    checkOutput("stepsST", 8'(steps), 8'd4);
    applyStimulus(4'hF, 0, 0, steps);
    checkOutput("stepsHLT", 8'(steps), 8'd3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("haltSticky", 8'(halted), 8'd1);
      checkOutput("haltState", 8'(stateDbg), 8'd10);
      @(posedge clk);
      #1;
    end
    checkOutput("regWritePulses", 8'(regWCount - rw0), 8'd2);
    checkOutput("memEnablePulses", 8'(memCount - mem0), 8'd1);

    // Test B: JZ taken and not taken, JMP.
    $display("[TB] branches");
    doReset();
    applyStimulus(4'h2, 1, 0, steps);
    checkOutput("stepsSUBhold", 8'(steps), 8'd8);
    applyStimulus(4'h9, 0, 0, steps);
    checkOutput("stepsJZ", 8'(steps), 8'd4);
    checkOutput("jzTakenPcEn", 8'(jPcEn), 8'd1);
    checkOutput("jzTakenPcSel", 8'(jPcSel), 8'd1);
    applyStimulus(4'h2, 0, 0, steps);
    applyStimulus(4'h9, 1, 0, steps);
    checkOutput("jzNotTakenPcEn", 8'(jPcEn), 8'd0);
    checkOutput("jzNotTakenPcSel", 8'(jPcSel), 8'd1);
    applyStimulus(4'h8, 0, 0, steps);
    checkOutput("jmpPcEn", 8'(jPcEn), 8'd1);

    // Test C: LD single-stepped with alternating step.
    $display("[TB] stretched LD");
    ens0 = enNoStep;
    applyStimulus(4'h6, 2, 1, steps);
    checkOutput("stepsLD", 8'(steps), 8'd5);
    checkOutput("enableWhileIdle", 8'(enNoStep - ens0), 8'd0);

    // Test D: reset in MEM_WR with zflag previously set.
    $display("[TB] reset during store");
    applyStimulus(4'h2, 1, 0, steps);
    opcode = 4'h7;
    step = 1'b1;
    for (int k = 0; k < 20 && mState() != S_MWR; k++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("reachMemWr", 8'(mState()), 8'd8);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rstMemEnable", 8'(memEnable), 8'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step = 1'b0;
    @(negedge clk);
    checkOutput("rstToFetch1", 8'(stateDbg), 8'd0);
    @(posedge clk);
    #1;
    applyStimulus(4'h9, 0, 0, steps);
    checkOutput("stepsJZafterRst", 8'(steps), 8'd7);
    checkOutput("zflagCleared", 8'(jPcEn), 8'd0);

    // Test E: reserved opcode, then NOP.
    $display("[TB] illegal opcode");
    doReset();
    applyStimulus(4'hB, 0, 0, steps);
    checkOutput("stepsIllegal", 8'(steps), 8'd6);
    @(negedge clk);
`ifdef ILLEGAL_TRAP_EN
    checkOutput("trapIllegal", 8'(illegal), 8'd1);
    checkOutput("trapHalted", 8'(halted), 8'd1);
`else
    checkOutput("nopIllegal", 8'(illegal), 8'd0);
    checkOutput("nopState", 8'(stateDbg), 8'd0);
`endif
    @(posedge clk);
    #1;
    doReset();
    applyStimulus(4'h0, 0, 0, steps);
    checkOutput("stepsNOPhold", 8'(steps), 8'd6);

    // Test F: randomized run with random resets.
    $display("[TB] random run");
    doReset();
    for (int i = 0; i < 800; i++) begin
      if (mState() == S_F1) opcode = 4'($urandom_range(0, 15));
      step  = ($urandom_range(0, 3) != 0);
      zero  = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 59) == 0) ||
              (mState() == S_HLT && $urandom_range(0, 7) == 0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    step = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
